ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage of the 16-bit pipelined core. It sits directly downstream of the ID/EX pipeline register and consumes its EX_* outputs. It computes the ALU or compare result, runs a multi-cycle iterative multiply, and registers the results into the MEM-side outputs, which serve as the EX/MEM latch. During a multiply it raises hold_req, which drives hold_flag of the upstream pipeline registers.

Parameters:
CPU_WIDTH, 16, datapath width (even, ≥8)
MUL_CYCLES, CPU_WIDTH, number of shift-add iterations of the multiplier

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
EX_rd  in  3  destination register index
EX_RD  in  CPU_WIDTH  rd operand value
EX_RS  in  CPU_WIDTH  rs operand value
EX_IMM  in  CPU_WIDTH  immediate
EX_IMMop  in  1  1: immediate is shifted left by CPU_WIDTH/2 (load-upper)
EX_ALUop  in  3  ALU operation
EX_CMPop  in  2  compare operation
EX_RegWe  in  1  register write enable
EX_RWSel  in  1  writeback source select (pass-through)
EX_ABSel  in  1  swap operands A/B
EX_IMMSel  in  1  B operand = immediate
EX_mem_ctrl  in  1  memory access control (pass-through)
flush  in  1  kill the instruction in EX and abort any multiply
MEM_rd  out  3  registered rd
MEM_ALU_res  out  CPU_WIDTH  registered result
MEM_store_data  out  CPU_WIDTH  registered store data (= EX_RD)
MEM_RegWe  out  1  registered write enable
MEM_RWSel  out  1  registered RWSel
MEM_mem_ctrl  out  1  registered mem_ctrl
cmp_flag  out  1  condition flag
hold_req  out  1  stall request to upstream stages (combinational)

Behaviour:
- Reset (async, rst_n=0): all MEM_* = 0, cmp_flag = 0, FSM = IDLE, counter = 0. Reset mid-multiply discards the multiply.
- Operand formation:
  - IMMx = EX_IMMop ? EX_IMM << (CPU_WIDTH/2) : EX_IMM.
  - A0 = EX_RD; B0 = EX_IMMSel ? IMMx : EX_RS.
  - EX_ABSel=1 swaps them: A = B0, B = A0.
- ALUop encoding:
  - 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SHR (logical); shift amount is B[log2(CPU_WIDTH)−1:0].
  - 7 MUL, returning the low CPU_WIDTH bits of the product.
  - All arithmetic is modulo 2^CPU_WIDTH.
- CMPop encoding:
  - 0 none: flag held.
  - 1 EQ: flag = (A==B).
  - 2 LTU: flag = A<B unsigned.
  - 3 LTS: flag = A<B signed.
  - The flag updates at the same edge the instruction is registered. No update on flush, and no update while MUL is in progress.
- Single-cycle ops (ALUop≠7): latency 1. On the next edge, MEM_* load the result and the pass-through fields. hold_req = 0.
- Multiply FSM:
  - IDLE: if ALUop==7 and flush=0, hold_req=1. At the edge, latch A and B, clear the accumulator, set counter=0, go to BUSY. MEM_* load a bubble (RegWe=0, mem_ctrl=0, other fields 0).
  - BUSY: hold_req=1. Each edge performs one shift-add step and increments the counter; after MUL_CYCLES steps go to DONE. MEM_* receive a bubble every cycle.
  - DONE: hold_req=0. At the edge, MEM_* load the product plus the EX_rd/RegWe/RWSel/mem_ctrl fields (still held stable by upstream). Go to IDLE; a MUL still on the inputs in DONE does not restart.
  - Timing: hold_req is high for MUL_CYCLES+1 cycles. The result appears at the MUL_CYCLES+2 edge after the MUL enters EX.
- Flush:
  - Has highest priority after reset. hold_req is forced to 0.
  - The next edge loads a bubble into MEM_* and forces FSM to IDLE, aborting a BUSY/DONE multiply.
  - cmp_flag unchanged.
- All-zero inputs (upstream bubble) execute ADD with RegWe=0 and have no side effects.

Decomposition:
- Shared package (para.v) holds:
  - ALUop codes ALU_ADD…ALU_MUL.
  - CMPop codes CMP_NONE/EQ/LTU/LTS.
  - FSM state encodings.
- One sub-module: mul_iter, the shift-add multiplier datapath with start/busy/done; ex_stage owns the ALU mux and the output registers.

Test Plan:
- ADD imm: RD=0x0010, IMM=0x0005, IMMSel=1, RegWe=1, rd=3 → next edge MEM_ALU_res=0x0015, MEM_rd=3, MEM_RegWe=1, hold_req=0 throughout.
- SUB swapped + LTS: RD=0x0003, RS=0xFFFE, ABSel=1, ALUop=SUB, CMPop=LTS → MEM_ALU_res=0xFFFB, cmp_flag=1.
- Load-upper: IMM=0x00AB, IMMop=1, IMMSel=1, RD=0, ADD → MEM_ALU_res=0xAB00.
- MUL: RD=300, RS=7, ALUop=7 → hold_req high 17 cycles; MEM_RegWe=0 during them; result 0x0834 at edge 18; then 0x0100×0x0100 → 0x0000.
- Flush mid-MUL: assert flush at BUSY cycle 5 → hold_req drops that cycle, next edge MEM_RegWe=0, FSM IDLE, following ADD completes in 1 cycle.
- Reset mid-MUL: rst_n low during BUSY → all outputs 0 immediately, hold_req=0; after release a new MUL takes the full 17-cycle hold.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU/compare opcodes and multiplier FSM states.
package ex_stage_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_MUL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        CMP_NONE = 2'd0,
        CMP_EQ   = 2'd1,
        CMP_LTU  = 2'd2,
        CMP_LTS  = 2'd3
    } cmp_op_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage, bundled as one interface.
interface ex_stage_if #(
    parameter int CPU_WIDTH = 16
);
    logic [2:0]           EX_rd;
    logic [CPU_WIDTH-1:0] EX_RD;
    logic [CPU_WIDTH-1:0] EX_RS;
    logic [CPU_WIDTH-1:0] EX_IMM;
    logic                 EX_IMMop;
    logic [2:0]           EX_ALUop;
    logic [1:0]           EX_CMPop;
    logic                 EX_RegWe;
    logic                 EX_RWSel;
    logic                 EX_ABSel;
    logic                 EX_IMMSel;
    logic                 EX_mem_ctrl;
    logic                 flush;

    logic [2:0]           MEM_rd;
    logic [CPU_WIDTH-1:0] MEM_ALU_res;
    logic [CPU_WIDTH-1:0] MEM_store_data;
    logic                 MEM_RegWe;
    logic                 MEM_RWSel;
    logic                 MEM_mem_ctrl;
    logic                 cmp_flag;
    logic                 hold_req;

    modport master (
        output EX_rd, EX_RD, EX_RS, EX_IMM, EX_IMMop, EX_ALUop, EX_CMPop,
               EX_RegWe, EX_RWSel, EX_ABSel, EX_IMMSel, EX_mem_ctrl, flush,
        input  MEM_rd, MEM_ALU_res, MEM_store_data, MEM_RegWe, MEM_RWSel,
               MEM_mem_ctrl, cmp_flag, hold_req
    );

    modport slave (
        input  EX_rd, EX_RD, EX_RS, EX_IMM, EX_IMMop, EX_ALUop, EX_CMPop,
               EX_RegWe, EX_RWSel, EX_ABSel, EX_IMMSel, EX_mem_ctrl, flush,
        output MEM_rd, MEM_ALU_res, MEM_store_data, MEM_RegWe, MEM_RWSel,
               MEM_mem_ctrl, cmp_flag, hold_req
    );
endinterface

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, low W bits of the product.
module ex_stage_mul_iter
    import ex_stage_pkg::*;
#(
    parameter int W = 16,
    parameter int N = W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_product
);
    localparam int CW = $clog2(N) + 1;

    mul_state_e    r_state;
    mul_state_e    w_next;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_mcand;
    logic [W-1:0]  r_mplier;
    logic [W-1:0]  r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= MUL_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MUL_IDLE: if (i_start) w_next = MUL_BUSY;
            MUL_BUSY: if (r_cnt == CW'(N - 1)) w_next = MUL_DONE;
            MUL_DONE: w_next = MUL_IDLE;
            default:  w_next = MUL_IDLE;
        endcase
        if (i_abort) w_next = MUL_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (!i_abort) begin
            if (r_state == MUL_IDLE && i_start) begin
                r_cnt    <= '0;
                r_mcand  <= i_a;
                r_mplier <= i_b;
                r_acc    <= '0;
            end else if (r_state == MUL_BUSY) begin
                // Multiplicand walks left as multiplier bits are consumed LSB first.
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    assign o_busy    = (r_state == MUL_BUSY);
    assign o_done    = (r_state == MUL_DONE);
    assign o_product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand formation, ALU/compare, multi-cycle multiply control and the EX/MEM latch.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int CPU_WIDTH  = 16,
    parameter int MUL_CYCLES = CPU_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);
    localparam int SHW = $clog2(CPU_WIDTH);

    logic [CPU_WIDTH-1:0] w_immx;
    logic [CPU_WIDTH-1:0] w_b0;
    logic [CPU_WIDTH-1:0] w_a;
    logic [CPU_WIDTH-1:0] w_b;
    logic [CPU_WIDTH-1:0] w_alu_res;
    logic [CPU_WIDTH-1:0] w_product;
    logic                 w_cmp_res;
    logic                 w_is_mul;
    logic                 w_mul_req;
    logic                 w_mul_start;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_idle;
    logic                 w_bubble;
    logic                 w_load_cmp;

    logic [2:0]           r_rd;
    logic [CPU_WIDTH-1:0] r_res;
    logic [CPU_WIDTH-1:0] r_store;
    logic                 r_regwe;
    logic                 r_rwsel;
    logic                 r_memctrl;
    logic                 r_cmp_flag;

    assign w_immx = bus.EX_IMMop ? (bus.EX_IMM << (CPU_WIDTH / 2)) : bus.EX_IMM;
    assign w_b0   = bus.EX_IMMSel ? w_immx : bus.EX_RS;
    assign w_a    = bus.EX_ABSel ? w_b0 : bus.EX_RD;
    assign w_b    = bus.EX_ABSel ? bus.EX_RD : w_b0;

    always_comb begin
        w_alu_res = w_a + w_b;
        case (alu_op_e'(bus.EX_ALUop))
            ALU_ADD: w_alu_res = w_a + w_b;
            ALU_SUB: w_alu_res = w_a - w_b;
            ALU_AND: w_alu_res = w_a & w_b;
            ALU_OR:  w_alu_res = w_a | w_b;
            ALU_XOR: w_alu_res = w_a ^ w_b;
            ALU_SHL: w_alu_res = w_a << w_b[SHW-1:0];
            ALU_SHR: w_alu_res = w_a >> w_b[SHW-1:0];
            ALU_MUL: w_alu_res = w_product;
            default: w_alu_res = w_a + w_b;
        endcase
    end

    always_comb begin
        w_cmp_res = r_cmp_flag;
        case (cmp_op_e'(bus.EX_CMPop))
            CMP_EQ:  w_cmp_res = (w_a == w_b);
            CMP_LTU: w_cmp_res = (w_a < w_b);
            CMP_LTS: w_cmp_res = ($signed(w_a) < $signed(w_b));
            default: w_cmp_res = r_cmp_flag;
        endcase
    end

    assign w_is_mul    = (alu_op_e'(bus.EX_ALUop) == ALU_MUL);
    assign w_mul_req   = w_is_mul && !bus.flush;
    assign w_idle      = !w_busy && !w_done;
    assign w_mul_start = w_mul_req && w_idle;

    ex_stage_mul_iter #(
        .W (CPU_WIDTH),
        .N (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_req),
        .i_abort   (bus.flush),
        .i_a       (w_a),
        .i_b       (w_b),
        .o_busy    (w_busy),
        .o_done    (w_done),
        .o_product (w_product)
    );

    // The DONE cycle registers the product with the still-held MUL fields, so no stall there.
    assign w_bubble   = bus.flush || w_mul_start || w_busy;
    assign w_load_cmp = !bus.flush && ((w_idle && !w_is_mul) || w_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd       <= '0;
            r_res      <= '0;
            r_store    <= '0;
            r_regwe    <= 1'b0;
            r_rwsel    <= 1'b0;
            r_memctrl  <= 1'b0;
            r_cmp_flag <= 1'b0;
        end else begin
            if (w_bubble) begin
                r_rd      <= '0;
                r_res     <= '0;
                r_store   <= '0;
                r_regwe   <= 1'b0;
                r_rwsel   <= 1'b0;
                r_memctrl <= 1'b0;
            end else begin
                r_rd      <= bus.EX_rd;
                r_res     <= w_alu_res;
                r_store   <= bus.EX_RD;
                r_regwe   <= bus.EX_RegWe;
                r_rwsel   <= bus.EX_RWSel;
                r_memctrl <= bus.EX_mem_ctrl;
            end
            if (w_load_cmp) r_cmp_flag <= w_cmp_res;
        end
    end

    assign bus.hold_req       = rst_n && !bus.flush && (w_mul_start || w_busy);
    assign bus.MEM_rd         = r_rd;
    assign bus.MEM_ALU_res    = r_res;
    assign bus.MEM_store_data = r_store;
    assign bus.MEM_RegWe      = r_regwe;
    assign bus.MEM_RWSel      = r_rwsel;
    assign bus.MEM_mem_ctrl   = r_memctrl;
    assign bus.cmp_flag       = r_cmp_flag;

endmodule

// File: tb/tb_ex_stage.sv
// Directed scoreboard bench for ex_stage: ALU/compare ops, iterative multiply, flush and reset.
module tb_ex_stage;
    import ex_stage_pkg::*;

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic [15:0] store;
        logic [2:0]  rd;
        logic        regwe;
        logic        rwsel;
        logic        memctrl;
        logic        flag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic exp_flag;
    exp_t sb[$];

    ex_stage_if #(.CPU_WIDTH(16)) bus ();

    ex_stage #(
        .CPU_WIDTH  (16),
        .MUL_CYCLES (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_res(input logic [15:0] a, input logic [15:0] b,
                                              input logic [2:0] op);
        logic [31:0] p;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << b[3:0];
            3'd6: return a >> b[3:0];
            default: begin
                p = 32'(a) * 32'(b);
                return p[15:0];
            end
        endcase
    endfunction

    function automatic logic model_cmp(input logic [15:0] a, input logic [15:0] b,
                                       input logic [1:0] op, input logic old);
        case (op)
            2'd1: return a == b;
            2'd2: return a < b;
            2'd3: return $signed(a) < $signed(b);
            default: return old;
        endcase
    endfunction

    task automatic drive(input logic [2:0] rd, input logic [15:0] rdv, input logic [15:0] rsv,
                         input logic [15:0] imm, input logic immop, input logic [2:0] alu,
                         input logic [1:0] cmp, input logic regwe, input logic rwsel,
                         input logic absel, input logic immsel, input logic memctrl,
                         output logic [15:0] a, output logic [15:0] b);
        logic [15:0] immx;
        logic [15:0] b0;
        bus.EX_rd = rd;      bus.EX_RD = rdv;       bus.EX_RS = rsv;
        bus.EX_IMM = imm;    bus.EX_IMMop = immop;  bus.EX_ALUop = alu;
        bus.EX_CMPop = cmp;  bus.EX_RegWe = regwe;  bus.EX_RWSel = rwsel;
        bus.EX_ABSel = absel; bus.EX_IMMSel = immsel; bus.EX_mem_ctrl = memctrl;
        immx = immop ? {imm[7:0], 8'h00} : imm;
        b0   = immsel ? immx : rsv;
        a    = absel ? b0 : rdv;
        b    = absel ? rdv : b0;
    endtask

    task automatic drive_idle();
        logic [15:0] a;
        logic [15:0] b;
        drive(3'd0, '0, '0, '0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a, b);
    endtask

    task automatic check_out();
        exp_t e;
        chk("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_res"},     32'(bus.MEM_ALU_res),    32'(e.res));
            chk({e.tag, "_rd"},      32'(bus.MEM_rd),         32'(e.rd));
            chk({e.tag, "_regwe"},   32'(bus.MEM_RegWe),      32'(e.regwe));
            chk({e.tag, "_rwsel"},   32'(bus.MEM_RWSel),      32'(e.rwsel));
            chk({e.tag, "_memctrl"}, 32'(bus.MEM_mem_ctrl),   32'(e.memctrl));
            chk({e.tag, "_store"},   32'(bus.MEM_store_data), 32'(e.store));
            chk({e.tag, "_flag"},    32'(bus.cmp_flag),       32'(e.flag));
        end
    endtask

    task automatic single(input string tag, input logic [2:0] rd, input logic [15:0] rdv,
                          input logic [15:0] rsv, input logic [15:0] imm, input logic immop,
                          input logic [2:0] alu, input logic [1:0] cmp, input logic regwe,
                          input logic absel, input logic immsel);
        logic [15:0] a;
        logic [15:0] b;
        exp_t e;
        drive(rd, rdv, rsv, imm, immop, alu, cmp, regwe, 1'b1, absel, immsel, 1'b1, a, b);
        exp_flag = model_cmp(a, b, cmp, exp_flag);
        e = '{tag, model_res(a, b, alu), rdv, rd, regwe, 1'b1, 1'b1, exp_flag};
        sb.push_back(e);
        #1;
        chk({tag, "_hold"}, 32'(bus.hold_req), 32'd0);
        @(posedge clk); #1;
        check_out();
    endtask

    task automatic mul_op(input string tag, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] a;
        logic [15:0] b;
        int holds;
        int edges;
        int bad;
        bit got;
        exp_t e;
        drive(3'd5, x, y, '0, 1'b0, 3'd7, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, b);
        e = '{tag, model_res(a, b, 3'd7), x, 3'd5, 1'b1, 1'b1, 1'b0, exp_flag};
        sb.push_back(e);
        holds = 0; edges = 0; bad = 0; got = 0;
        while (!got && edges < 40) begin
            #1;
            if (bus.hold_req === 1'b1) holds++;
            @(posedge clk); #1;
            edges++;
            if (bus.MEM_RegWe === 1'b1) got = 1;
            else if (bus.MEM_ALU_res !== 16'h0 || bus.MEM_rd !== 3'd0) bad++;
        end
        drive_idle();
        chk({tag, "_edges"}, 32'(edges), 32'd18);
        chk({tag, "_holds"}, 32'(holds), 32'd17);
        chk({tag, "_bubbles"}, 32'(bad), 32'd0);
        check_out();
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        vectors     = 0;
        miscompares = 0;
        exp_flag    = 1'b0;
        rst_n       = 1'b0;
        bus.flush   = 1'b0;
        drive_idle();
        #2;
        chk("rst_res",   32'(bus.MEM_ALU_res), 32'd0);
        chk("rst_regwe", 32'(bus.MEM_RegWe),   32'd0);
        chk("rst_flag",  32'(bus.cmp_flag),    32'd0);
        chk("rst_hold",  32'(bus.hold_req),    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // name        rd    RD       RS       IMM      up  alu  cmp we ab is
        single("add_imm", 3'd3, 16'h0010, 16'h0000, 16'h0005, 0, 3'd0, 2'd0, 1, 0, 1);
        single("sub_lts", 3'd1, 16'h0003, 16'hFFFE, 16'h0000, 0, 3'd1, 2'd3, 1, 1, 0);
        single("lui",     3'd2, 16'h0000, 16'h0000, 16'h00AB, 1, 3'd0, 2'd0, 1, 0, 1);
        single("and",     3'd4, 16'hF0F0, 16'h3C3C, 16'h0000, 0, 3'd2, 2'd0, 1, 0, 0);
        single("or_ltu",  3'd5, 16'hF0F0, 16'h3C3C, 16'h0000, 0, 3'd3, 2'd2, 1, 0, 0);
        single("xor_eq",  3'd6, 16'h1234, 16'h1234, 16'h0000, 0, 3'd4, 2'd1, 1, 0, 0);
        single("shl",     3'd7, 16'h0001, 16'h0024, 16'h0000, 0, 3'd5, 2'd0, 1, 0, 0);
        single("shr_imm", 3'd1, 16'h8000, 16'h0000, 16'h000F, 0, 3'd6, 2'd2, 1, 0, 1);
        single("ltu_set", 3'd2, 16'h0001, 16'hFFFF, 16'h0000, 0, 3'd0, 2'd2, 1, 0, 0);

        // A flushed EQ with unequal operands must neither write nor clear the flag.
        drive(3'd3, 16'h0001, 16'h0002, '0, 1'b0, 3'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, a, b);
        bus.flush = 1'b1;
        #1;
        chk("flush_hold", 32'(bus.hold_req), 32'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_regwe", 32'(bus.MEM_RegWe),    32'd0);
        chk("flush_mem",   32'(bus.MEM_mem_ctrl), 32'd0);
        chk("flush_flag",  32'(bus.cmp_flag),     32'(exp_flag));

        mul_op("mul_300x7", 16'd300, 16'd7);
        mul_op("mul_wrap",  16'h0100, 16'h0100);
        mul_op("mul_mix",   16'hBEEF, 16'h1235);

        drive(3'd5, 16'd300, 16'd7, '0, 1'b0, 3'd7, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, b);
        repeat (5) @(posedge clk);
        #1;
        chk("fmul_hold_busy", 32'(bus.hold_req), 32'd1);
        bus.flush = 1'b1;
        #1;
        chk("fmul_hold_flush", 32'(bus.hold_req), 32'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("fmul_regwe", 32'(bus.MEM_RegWe), 32'd0);
        chk("fmul_flag",  32'(bus.cmp_flag),  32'(exp_flag));
        single("post_flush_add", 3'd6, 16'h1000, 16'h0234, 16'h0000, 0, 3'd0, 2'd0, 1, 0, 0);
        single("bubble", 3'd0, 16'h0000, 16'h0000, 16'h0000, 0, 3'd0, 2'd0, 0, 0, 0);

        single("flag_set", 3'd1, 16'h0005, 16'h0005, 16'h0000, 0, 3'd0, 2'd1, 1, 0, 0);
        drive(3'd5, 16'd300, 16'd7, '0, 1'b0, 3'd7, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, b);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_flag = 1'b0;
        #1;
        chk("rmul_res",   32'(bus.MEM_ALU_res),    32'd0);
        chk("rmul_rd",    32'(bus.MEM_rd),         32'd0);
        chk("rmul_store", 32'(bus.MEM_store_data), 32'd0);
        chk("rmul_regwe", 32'(bus.MEM_RegWe),      32'd0);
        chk("rmul_flag",  32'(bus.cmp_flag),       32'd0);
        chk("rmul_hold",  32'(bus.hold_req),       32'd0);
        drive_idle();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        mul_op("mul_after_rst", 16'd300, 16'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
